// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_slv_state_t;

  localparam int WIN_W      = 12;             // 4 KB decode window
  localparam int WORD_SHIFT = 2;              // byte address -> word index
  localparam int OFF_W      = WIN_W - WORD_SHIFT;
  localparam int CNT_W      = 4;              // holds WAIT_STATES up to 15

endpackage

// File: rtl/apb_regfile_core.sv
// Word-addressed register file: one write port, one combinational read port,
// constant ID word at index 0.
module apb_regfile_core #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001,
  parameter int                  IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [IDX_W-1:0]               raddr,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  // Index 0 is the constant ID, so storage starts at 1.
  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

  // NOTE: the file is small and software expects it cleared, so every word is
  // reset here; larger memories normally stay unreset to allow RAM mapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0 && int'(waddr) < NUM_REGS) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr == '0)                 rdata = ID_VALUE;
    else if (int'(raddr) < NUM_REGS) rdata = mem[raddr];
  end

  always_comb begin
    regs_o[0 +: DATA_WIDTH] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer for one slave slot: window decode, wait-state insertion,
// PSLVERR on bad accesses, backed by apb_regfile_core.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0001_F000,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [ADDR_WIDTH-1:0]          paddr_i,
  input  logic [DATA_WIDTH-1:0]          pwdata_i,
  output logic [DATA_WIDTH-1:0]          prdata_o,
  output logic                           pready_o,
  output logic                           pslverr_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_slv_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  setup;
  logic [OFF_W-1:0]      word_off;
  logic                  dec_err;
  logic                  we;
  logic [DATA_WIDTH-1:0] rd_data;

  assign setup    = psel_i & ~penable_i;
  assign word_off = paddr_i[WIN_W-1:WORD_SHIFT];
  assign dec_err  = (paddr_i[ADDR_WIDTH-1:WIN_W] != BASE_ADDR[ADDR_WIDTH-1:WIN_W])
                  | (paddr_i[WORD_SHIFT-1:0] != '0)
                  | (int'(word_off) >= NUM_REGS)
                  | (pwrite_i & (word_off == '0));

  apb_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (idx_q),
    .wdata  (wdata_q),
    .raddr  (word_off[IDX_W-1:0]),
    .rdata  (rd_data),
    .regs_o (regs_o)
  );

  // Outputs depend only on registered state, so they hold steady through ACCESS.
  // NOTE: combinational blocks use blocking '=' with a default first, which
  // keeps every path assigned and avoids latch inference.
  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    pready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) state_d = ACCESS;
      end
      ACCESS: begin
        pready_o = (cnt_q == '0);
        if (!psel_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          we      = write_q & ~err_q;
        end
      end
      default: state_d = IDLE;
    endcase
    pslverr_o = pready_o & err_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      prdata_o <= '0;
    end else if (state_q == IDLE && setup) begin
      cnt_q    <= CNT_W'(WAIT_STATES);
      idx_q    <= word_off[IDX_W-1:0];
      write_q  <= pwrite_i;
      err_q    <= dec_err;
      wdata_q  <= pwdata_i;
      prdata_o <= (dec_err || pwrite_i) ? '0 : rd_data;
    end else if (state_q == ACCESS && psel_i && penable_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with 1 wait state and one
// with 3, sharing the bus signals but selected by separate psel lines.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel1, psel3, penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [31:0]  prdata1, prdata3;
  logic         pready1, pready3, pslverr1, pslverr3;
  logic [511:0] regs1, regs3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel1), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata1), .pready_o(pready1),
    .pslverr_o(pslverr1), .regs_o(regs1)
  );

  apb_slave_regfile #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata3), .pready_o(pready3),
    .pslverr_o(pslverr3), .regs_o(regs3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [511:0] r, input int i);
    return r[i*32 +: 32];
  endfunction

  task automatic bus_idle();
    @(posedge clk); #1;
    psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Runs SETUP + ACCESS; returns at #1 inside the pready cycle so a following
  // call issues its SETUP in the very next cycle.
  task automatic apb_xfer(input bit use3, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output bit er, output int lat);
    @(posedge clk); #1;
    check("ready_low_at_setup", 32'(use3 ? pready3 : pready1), 32'd0);
    psel1 = !use3; psel3 = use3; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (!(use3 ? pready3 : pready1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(use3 ? pready3 : pready1)) check("ready_timeout", 32'd0, 32'd1);
    rd = use3 ? prdata3 : prdata1;
    er = use3 ? pslverr3 : pslverr1;
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat;
  bit          seen;

  initial begin
    rst_n = 1'b0; psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    model[0] = ID;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_pready", 32'(pready1), 32'd0);
    check("rst_pslverr", 32'(pslverr1), 32'd0);
    check("rst_prdata", prdata1, 32'd0);
    check("rst_reg2", word(regs1, 2), 32'd0);
    check("rst_reg0_id", word(regs1, 0), ID);

    // ID read, latency SETUP+2
    apb_xfer(0, 0, 32'h0001_F000, 32'h0, rd, er, lat);
    check("id_data", rd, ID);
    check("id_err", 32'(er), 32'd0);
    check("id_lat", 32'(lat), 32'd2);
    bus_idle();
    check("ready_one_cycle", 32'(pready1), 32'd0);

    // write then read back
    apb_xfer(0, 1, 32'h0001_F008, 32'hDEAD_BEEF, rd, er, lat);
    check("wr2_err", 32'(er), 32'd0);
    check("wr2_prdata", rd, 32'd0);
    bus_idle();
    model[2] = 32'hDEAD_BEEF;
    check("wr2_regs", word(regs1, 2), 32'hDEAD_BEEF);
    apb_xfer(0, 0, 32'h0001_F008, 32'h0, rd, er, lat);
    check("rd2_data", rd, 32'hDEAD_BEEF);

    // out-of-window read right after a non-zero read
    apb_xfer(0, 0, 32'h0002_F004, 32'h0, rd, er, lat);
    check("oow_err", 32'(er), 32'd1);
    check("oow_data", rd, 32'd0);
    bus_idle();
    check("err_only_with_ready", 32'(pslverr1), 32'd0);

    // errored writes leave the file untouched
    apb_xfer(0, 1, 32'h0001_F000, 32'h1234_5678, rd, er, lat);
    check("wr_id_err", 32'(er), 32'd1);
    apb_xfer(0, 1, 32'h0001_F002, 32'h5555_5555, rd, er, lat);
    check("wr_mis2_err", 32'(er), 32'd1);
    apb_xfer(0, 1, 32'h0001_F00A, 32'h6666_6666, rd, er, lat);
    check("wr_misA_err", 32'(er), 32'd1);
    apb_xfer(0, 1, 32'h0001_F040, 32'h7777_7777, rd, er, lat);
    check("wr_oor_err", 32'(er), 32'd1);
    apb_xfer(0, 0, 32'h0001_F03C, 32'h0, rd, er, lat);
    check("rd_last_ok", 32'(er), 32'd0);
    bus_idle();
    for (int i = 0; i < 16; i++) check($sformatf("file_word%0d", i), word(regs1, i), model[i]);

    // back-to-back 4-beat write burst, then 4-beat read burst
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, 1, 32'h0001_F010 + 32'(4*i), 32'hC0DE_0000 + 32'(i*17), rd, er, lat);
      check($sformatf("bw%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("bw%0d_err", i), 32'(er), 32'd0);
      model[4+i] = 32'hC0DE_0000 + 32'(i*17);
    end
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, 0, 32'h0001_F010 + 32'(4*i), 32'h0, rd, er, lat);
      check($sformatf("br%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("br%0d_data", i), rd, model[4+i]);
    end
    bus_idle();

    // three wait states
    apb_xfer(1, 0, 32'h0001_F000, 32'h0, rd, er, lat);
    check("ws3_lat", 32'(lat), 32'd4);
    check("ws3_data", rd, ID);
    bus_idle();

    // psel dropped mid-wait on a write: aborted, no pready, no write
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0001_F00C; pwdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (pready3) seen = 1'b1;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_no_write", word(regs3, 3), 32'd0);
    apb_xfer(1, 0, 32'h0001_F00C, 32'h0, rd, er, lat);
    check("abort_recover_data", rd, 32'd0);
    check("abort_recover_lat", 32'(lat), 32'd4);
    bus_idle();

    // reset in the middle of a read
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0001_F008;
    @(posedge clk); #1;
    penable = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_pready", 32'(pready1), 32'd0);
    check("midrst_prdata", prdata1, 32'd0);
    check("midrst_pslverr", 32'(pslverr1), 32'd0);
    check("midrst_reg2", word(regs1, 2), 32'd0);
    rst_n = 1'b1; psel1 = 1'b0; penable = 1'b0;
    apb_xfer(0, 0, 32'h0001_F000, 32'h0, rd, er, lat);
    check("post_rst_id", rd, ID);
    check("post_rst_lat", 32'(lat), 32'd2);
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
